// File: rtl/rv64g_pkg.sv
// Shared RV64G core definitions.
//   NUM_REGS   : architectural registers tracked by the scoreboards (32 int + 32 fp)
//   LOCK_CNT_W : default width of a per-register outstanding-writer counter
package rv64g_pkg;
  localparam int NUM_REGS   = 64;
  localparam int LOCK_CNT_W = 2;
endpackage

// File: rtl/reg_lock_counter.sv
// One register's outstanding-writer counter.
//   clk_i/rst_i : clock, synchronous active-high reset
//   inc/dec     : add/remove one writer (both together cancel)
//   flush       : drop all writers; overrides inc/dec
//   sat         : counter is at its maximum value
//   nz          : counter is non-zero (current state)
//   nz_next     : counter will be non-zero after this edge
//   underflow   : single-cycle pulse, release seen while count is 0
module reg_lock_counter
  import rv64g_pkg::*;
#(
  parameter int CNT_W = LOCK_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  input  logic flush,
  output logic sat,
  output logic nz,
  output logic nz_next,
  output logic underflow
);
  logic [CNT_W-1:0] count, count_next;

  always_comb begin
    count_next = count;
    underflow  = 1'b0;
    if (flush) begin
      count_next = '0;
    end else if (inc && !dec) begin
      // Never wraps: the top refuses a set on a saturated, unreleased counter.
      count_next = count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count_next = count - 1'b1;
      else             underflow  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count <= '0;
    else       count <= count_next;
  end

  assign sat     = &count;
  assign nz      = |count;
  assign nz_next = |count_next;
endmodule

// File: rtl/reg_lock_tracker.sv
// Register scoreboard fed by the arbitration grant mask; releases on writeback
// and returns the lock vector to the grant checker.
//   clk_i/rst_i  : clock, synchronous active-high reset
//   set_valid_i  : lock request; set_ready_o gates acceptance
//   set_mask_i   : registers to lock
//   clr_valid_i  : writeback release; clr_mask_i registers to release
//   flush_i      : discard all locks (set/clr in the same cycle ignored)
//   locks_o      : registered lock vector
//   busy_o       : registered, any lock held
//   underflow_o  : sticky, release on an unlocked register
module reg_lock_tracker
  import rv64g_pkg::*;
#(
  parameter int CNT_W = LOCK_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_valid_i,
  output logic                set_ready_o,
  input  logic [NUM_REGS-1:0] set_mask_i,
  input  logic                clr_valid_i,
  input  logic [NUM_REGS-1:0] clr_mask_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] locks_o,
  output logic                busy_o,
  output logic                underflow_o
);
  localparam int NR = NUM_REGS;

  logic [NR-1:0] sat, nz, nz_next, uf, clr_eff, inc, dec;
  logic          set_fire;

  assign clr_eff     = clr_valid_i ? clr_mask_i : '0;
  // A same-cycle release on a saturated register frees the slot it needs.
  assign set_ready_o = ~|(set_mask_i & sat & ~clr_eff);
  assign set_fire    = set_valid_i & set_ready_o;
  assign inc         = set_fire ? set_mask_i : '0;
  assign dec         = clr_eff;

  // x0 never holds a lock and never reports underflow.
  assign sat[0]     = 1'b0;
  assign nz[0]      = 1'b0;
  assign nz_next[0] = 1'b0;
  assign uf[0]      = 1'b0;

  for (genvar r = 1; r < NR; r++) begin : g_cnt
    reg_lock_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .flush     (flush_i),
      .sat       (sat[r]),
      .nz        (nz[r]),
      .nz_next   (nz_next[r]),
      .underflow (uf[r])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locks_o     <= '0;
      busy_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      locks_o     <= nz_next;
      busy_o      <= |nz_next;
      underflow_o <= underflow_o | (|uf);
    end
  end

  // Current-state non-zero flags are not needed outside the counters.
  logic unused_nz;
  assign unused_nz = ^nz;
endmodule
